serial_receiver: RTL and testbench
==================================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the received word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of received words buffered; power of two.
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ClkTx  input  1  serial bit clock from the calculator transmitter, synchronous to Clk.
REQ-006 SHALL have port DataOut  input  1  serial data bit from the transmitter, MSB first.
REQ-007 SHALL have port DOutValid  input  1  frame-enable from the transmitter; high for the whole frame.
REQ-008 SHALL have port RdEn  input  1  pop request for the FIFO head.
REQ-009 SHALL have port ClrErr  input  1  clears the sticky Overflow flag.
REQ-010 SHALL have port RxData  output  DATA_WIDTH  FIFO head word (first-word fall-through).
REQ-011 SHALL have port RxValid  output  1  high while the FIFO is non-empty.
REQ-012 SHALL have port Full  output  1  high when the FIFO holds FIFO_DEPTH words.
REQ-013 SHALL have port Count  output  clog2(FIFO_DEPTH)+1  number of words held.
REQ-014 SHALL have port RxBusy  output  1  high while in SHIFT or DONE.
REQ-015 SHALL have port FrameErr  output  1  one-cycle pulse on an aborted frame.
REQ-016 SHALL have port Overflow  output  1  sticky flag, set when a completed word is dropped.

Function
REQ-017 SHALL detect a bit edge when ClkTx is 1 and its registered previous value is 0; it SHALL NOT add a synchronizer.
REQ-018 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-019 SHALL move IDLE->SHIFT on a bit edge with DOutValid=1, shifting DataOut into the shift register and setting the bit counter to 1.
REQ-020 SHALL, in SHIFT, on each bit edge with DOutValid=1, update shift <= {shift[DATA_WIDTH-2:0], DataOut} and increment the bit counter.
REQ-021 SHALL move SHIFT->DONE on the edge that captures bit DATA_WIDTH.
REQ-022 SHALL, in DONE, push the assembled word into the FIFO for exactly one cycle and return to IDLE; the word SHALL be visible on RxData with RxValid=1 one Clk cycle after the last bit is captured, if the FIFO was empty.
REQ-023 SHALL, if DOutValid is 0 in SHIFT, discard the partial word, pulse FrameErr for one cycle and return to IDLE.
REQ-024 SHALL ignore bit edges while DOutValid=0 in IDLE.
REQ-025 SHALL pop the head on RdEn=1 when Count>0; RdEn on an empty FIFO SHALL be ignored with no state change.
REQ-026 SHALL, on a push while full with RdEn=0, drop the new word, keep the stored words unchanged and set Overflow.
REQ-027 SHALL, on a simultaneous push and pop, perform both with Count unchanged; this includes the full case, which SHALL NOT set Overflow.
REQ-028 SHALL let the read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL clear Overflow on ClrErr=1; an overflow in the same cycle as ClrErr SHALL take priority and leave Overflow set.

Reset
REQ-030 SHALL, while Reset=0, force state to IDLE and clear the bit counter, the shift register, the pointers and the ClkTx history.
REQ-031 SHALL, while Reset=0, drive RxData=0, RxValid=0, Full=0, Count=0, RxBusy=0, FrameErr=0 and Overflow=0.
REQ-032 SHALL, on reset asserted mid-frame, lose the partial frame and not pulse FrameErr; after release it SHALL wait in IDLE for the next bit edge with DOutValid=1.

Verification
REQ-033 Bench SHALL check a single frame: send 32'hA5A50F0F MSB first at ClkTx = Clk/4 -> RxData=32'hA5A50F0F, RxValid=1 and Count=1 one cycle after bit 32; FrameErr=0.
REQ-034 Bench SHALL check an aborted frame: drop DOutValid after 10 bits -> one-cycle FrameErr pulse, Count stays 0, and the next full frame 32'h00000001 is received correctly.
REQ-035 Bench SHALL check overflow: send 5 frames 1..5 with no reads -> Full=1 after the 4th, Overflow=1 after the 5th, and pops return 1,2,3,4 then RxValid=0.
REQ-036 Bench SHALL check a push and pop in the same cycle: with the FIFO full, assert RdEn in the push cycle -> Count stays 4, Overflow=0, and the order is preserved.
REQ-037 Bench SHALL check reset mid-frame: assert Reset=0 after 16 bits -> all outputs 0 and no FrameErr; the following frame 32'hDEADBEEF is received intact.
REQ-038 Bench SHALL check ClrErr: assert ClrErr after an overflow -> Overflow=0 next cycle while the stored data is unchanged.

Source files
------------

// File: rtl/serial_receiver.sv
// serial_receiver: deserialises MSB-first frames from the transmitter into a small FWFT FIFO
module serial_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          ClkTx,
    input  logic                          DataOut,
    input  logic                          DOutValid,
    input  logic                          RdEn,
    input  logic                          ClrErr,
    output logic [DATA_WIDTH-1:0]         RxData,
    output logic                          RxValid,
    output logic                          Full,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          RxBusy,
    output logic                          FrameErr,
    output logic                          Overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q;
    logic                  clktx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         bits_q;
    logic                  frame_err_q;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  overflow_q;

    logic bit_edge;
    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic ovf_set;

    // ClkTx is already synchronous to Clk, so a single history flop gives the rising edge
    assign bit_edge = ClkTx & ~clktx_q;

    // A finished word sits in DONE for exactly one cycle, which is the push cycle
    assign push    = (state_q == DONE);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = RdEn && (count_q != '0);
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    // Frame assembly FSM: shift bits on each ClkTx edge, abort when the frame enable drops
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            clktx_q     <= 1'b0;
            shift_q     <= '0;
            bits_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            clktx_q     <= ClkTx;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bit_edge && DOutValid) begin
                        shift_q <= {shift_q[DATA_WIDTH-2:0], DataOut};
                        bits_q  <= CW'(1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!DOutValid) begin
                        shift_q     <= '0;
                        bits_q      <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (bit_edge) begin
                        shift_q <= {shift_q[DATA_WIDTH-2:0], DataOut};
                        bits_q  <= bits_q + CW'(1);
                        if (bits_q == CW'(DATA_WIDTH - 1))
                            state_q <= DONE;
                    end
                end
                DONE: begin
                    bits_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage array carries no reset; the read side masks it whenever the FIFO is empty
    always_ff @(posedge Clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= shift_q;
    end

    // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
            overflow_q <= ovf_set | (overflow_q & ~ClrErr);
        end
    end

    assign RxValid  = (count_q != '0);
    assign RxData   = RxValid ? mem_q[rd_ptr_q] : '0;
    assign Full     = full;
    assign Count    = count_q;
    assign RxBusy   = (state_q != IDLE);
    assign FrameErr = frame_err_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed and randomized frames checked against a queue model of the FIFO
module tb_serial_receiver;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ClkTx;
    logic        DataOut;
    logic        DOutValid;
    logic        RdEn;
    logic        ClrErr;
    logic [31:0] RxData;
    logic        RxValid;
    logic        Full;
    logic [2:0]  Count;
    logic        RxBusy;
    logic        FrameErr;
    logic        Overflow;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic        ovf = 1'b0;

    serial_receiver #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .ClkTx(ClkTx), .DataOut(DataOut),
        .DOutValid(DOutValid), .RdEn(RdEn), .ClrErr(ClrErr),
        .RxData(RxData), .RxValid(RxValid), .Full(Full), .Count(Count),
        .RxBusy(RxBusy), .FrameErr(FrameErr), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        @(negedge Clk);
        check({tag, "/valid"}, {31'd0, RxValid}, {31'd0, q.size() != 0});
        check({tag, "/data"}, RxData, (q.size() != 0) ? q[0] : 32'd0);
        check({tag, "/count"}, {29'd0, Count}, 32'(q.size()));
        check({tag, "/full"}, {31'd0, Full}, {31'd0, q.size() == 4});
        check({tag, "/ovf"}, {31'd0, Overflow}, {31'd0, ovf});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/data"}, RxData, 32'd0);
        check({tag, "/flags"}, {26'd0, RxValid, Full, RxBusy, FrameErr, Overflow, 1'b0}, 32'd0);
        check({tag, "/count"}, {29'd0, Count}, 32'd0);
    endtask

    // Bits go out at Clk/4: two cycles low, two high; the word is pushed on the cycle after the last capture
    task automatic send(input logic [31:0] w, input int n, input bit pop_end);
        DOutValid = 1'b1;
        for (int i = 0; i < n; i++) begin
            DataOut = w[31-i];
            ClkTx = 1'b0;
            step();
            step();
            ClkTx = 1'b1;
            step();
            if (pop_end && i == 31) RdEn = 1'b1;
            step();
            RdEn = 1'b0;
        end
        ClkTx = 1'b0;
        if (n == 32) DOutValid = 1'b0;
    endtask

    task automatic model_frame(input logic [31:0] w, input bit pop_end);
        if (pop_end && q.size() != 0) void'(q.pop_front());
        if (q.size() < 4) q.push_back(w);
        else ovf = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [31:0] w, input bit pop_end);
        send(w, 32, pop_end);
        model_frame(w, pop_end);
        check_model(tag);
    endtask

    task automatic pop(input string tag);
        check_model(tag);
        step();
        RdEn = 1'b1;
        step();
        RdEn = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic clr_pulse();
        step();
        ClrErr = 1'b1;
        step();
        ClrErr = 1'b0;
        ovf = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; ClkTx = 1'b0; DataOut = 1'b0; DOutValid = 1'b0; RdEn = 1'b0; ClrErr = 1'b0;
        step(); step(); step();
        @(negedge Clk);
        check_zero("reset");
        Reset = 1'b1;
        step(); step();

        frame("single", 32'hA5A50F0F, 1'b0);
        check("single/ferr", {31'd0, FrameErr}, 32'd0);
        pop("single_pop");
        check_model("single_empty");

        send(32'h12345678, 10, 1'b0);
        @(negedge Clk);
        check("abort/busy", {31'd0, RxBusy}, 32'd1);
        DOutValid = 1'b0;
        step();
        @(negedge Clk);
        check("abort/ferr_on", {31'd0, FrameErr}, 32'd1);
        check("abort/count", {29'd0, Count}, 32'd0);
        @(negedge Clk);
        check("abort/ferr_off", {31'd0, FrameErr}, 32'd0);
        step();
        frame("after_abort", 32'h00000001, 1'b0);
        pop("after_abort_pop");

        for (int k = 1; k <= 5; k++) frame($sformatf("ovf_fill%0d", k), 32'(k), 1'b0);
        clr_pulse();
        check_model("clrerr");
        ClrErr = 1'b1;
        send(32'h6, 32, 1'b0);
        ClrErr = 1'b0;
        model_frame(32'h6, 1'b0);
        check_model("ovf_priority");
        clr_pulse();
        check_model("clrerr2");
        for (int k = 0; k < 4; k++) pop($sformatf("ovf_pop%0d", k));
        check_model("ovf_empty");
        pop("empty_pop");
        check_model("empty_pop_after");

        for (int k = 0; k < 4; k++) frame($sformatf("pp_fill%0d", k), $urandom, 1'b0);
        frame("pushpop", $urandom, 1'b1);
        for (int k = 0; k < 4; k++) pop($sformatf("pp_pop%0d", k));
        check_model("pp_empty");

        frame("pre_reset", $urandom, 1'b0);
        send(32'hCAFEF00D, 16, 1'b0);
        @(negedge Clk);
        check("midreset/busy", {31'd0, RxBusy}, 32'd1);
        Reset = 1'b0;
        DOutValid = 1'b0;
        #1;
        check_zero("midreset");
        q.delete();
        ovf = 1'b0;
        step(); step();
        Reset = 1'b1;
        @(negedge Clk);
        check("midreset/ferr0", {31'd0, FrameErr}, 32'd0);
        @(negedge Clk);
        check("midreset/ferr1", {31'd0, FrameErr}, 32'd0);
        step();
        frame("post_reset", 32'hDEADBEEF, 1'b0);
        pop("post_reset_pop");

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0, 1: frame($sformatf("rnd%0d_frame", k), $urandom, 1'($urandom_range(0, 1)));
                2: pop($sformatf("rnd%0d_pop", k));
                default: clr_pulse();
            endcase
            check_model($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
